// File: rtl/matrix_3x3_pkg.sv
// ---------------------------------------------------------------------------
// matrix_3x3_pkg
//   Shared types and constants for the 3x3 window controller.
//   - state_e   : controller FSM states
//   - WIN_RxCy  : flat index of each window tap, index = row*3 + col,
//                 row 0 is the oldest line and col 0 the oldest column
//   - win_idx() : helper that computes the same index
// ---------------------------------------------------------------------------
package matrix_3x3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL0 = 3'd1,
        ST_FILL1 = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam int WIN_ROWS = 3;
    localparam int WIN_COLS = 3;
    localparam int WIN_TAPS = WIN_ROWS * WIN_COLS;

    localparam int WIN_R0C0 = 0;
    localparam int WIN_R0C1 = 1;
    localparam int WIN_R0C2 = 2;
    localparam int WIN_R1C0 = 3;
    localparam int WIN_R1C1 = 4;
    localparam int WIN_R1C2 = 5;
    localparam int WIN_R2C0 = 6;
    localparam int WIN_R2C1 = 7;
    localparam int WIN_R2C2 = 8;

    function automatic int win_idx(input int r, input int c);
        return r * WIN_COLS + c;
    endfunction

endpackage

// File: rtl/win_shift_3x3.sv
// ---------------------------------------------------------------------------
// win_shift_3x3
//   3x3 register array. On shift_en every row moves one column towards the
//   oldest position (c2 -> c1 -> c0) and the column tap enters at c2.
//
//   Ports:
//     clk, rst   clock and synchronous active-high reset (clears all taps)
//     shift_en   advance the window by one column
//     tap_col    new column, row r at [r*DATA_WIDTH +: DATA_WIDTH]
//     win        packed window, tap k at [k*DATA_WIDTH +: DATA_WIDTH],
//                k = row*3 + col
// ---------------------------------------------------------------------------
module win_shift_3x3
    import matrix_3x3_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           shift_en,
    input  logic [3*DATA_WIDTH-1:0]        tap_col,
    output logic [WIN_TAPS*DATA_WIDTH-1:0] win
);

    logic [DATA_WIDTH-1:0] win_q [WIN_TAPS];
    logic [DATA_WIDTH-1:0] win_d [WIN_TAPS];

    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            win_d[WIN_R0C0] = win_q[WIN_R0C1];
            win_d[WIN_R0C1] = win_q[WIN_R0C2];
            win_d[WIN_R0C2] = tap_col[0*DATA_WIDTH +: DATA_WIDTH];
            win_d[WIN_R1C0] = win_q[WIN_R1C1];
            win_d[WIN_R1C1] = win_q[WIN_R1C2];
            win_d[WIN_R1C2] = tap_col[1*DATA_WIDTH +: DATA_WIDTH];
            win_d[WIN_R2C0] = win_q[WIN_R2C1];
            win_d[WIN_R2C1] = win_q[WIN_R2C2];
            win_d[WIN_R2C2] = tap_col[2*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < WIN_TAPS; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            win_q <= win_d;
        end
    end

    always_comb begin
        win = '0;
        for (int r = 0; r < WIN_ROWS; r++) begin
            for (int c = 0; c < WIN_COLS; c++) begin
                win[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_q[win_idx(r, c)];
            end
        end
    end

endmodule

// File: rtl/matrix_3x3_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_3x3_ctrl
//   Turns a raster pixel stream into a 3x3 sliding window using two external
//   line FIFOs: line_a holds the previous line, line_b the line before that.
//
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     sof, pix_vld, pix_data    pixel stream in; sof marks pixel (0,0)
//     a_wr_en/a_wr_data         line_a write (every accepted pixel)
//     b_wr_en/b_wr_data         line_b write (line_a output, one cycle later)
//     a_rd_en, b_rd_en          FIFO pops; data returns the next cycle
//     a_rd_data, b_rd_data      FIFO read data
//     a_full/b_full/a_empty/b_empty  FIFO flags
//     win_vld, win_data         window out, tap k = row*3+col, r0/c0 oldest
//     win_row, win_col          coordinate of the window's bottom-right pixel
//     frame_done                pulse once both FIFOs are drained
//     err_abort                 pulse when sof arrives mid-frame
//     err_ovf                   sticky: a write hit a full FIFO
//     dbg_state                 current FSM state (state_e encoding)
//
//   Input handshake: the stream has no backpressure. A pixel is consumed in
//   every cycle where pix_vld is high and the controller accepts it (start of
//   frame from IDLE, or any non-sof pixel in FILL0/FILL1/RUN); otherwise it is
//   dropped. win_vld is a one-cycle qualifier with no ready; the consumer must
//   take the window in the cycle it is shown.
//
//   Pipeline: accept at T -> FIFO reads return and the window shifts at T+1
//   -> win_vld/win_data/win_row/win_col visible at T+2.
// ---------------------------------------------------------------------------
module matrix_3x3_ctrl
    import matrix_3x3_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int IMG_WIDTH  = 10,
    parameter int IMG_HEIGHT = 10,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sof,
    input  logic                    pix_vld,
    input  logic [DATA_WIDTH-1:0]   pix_data,
    output logic                    a_wr_en,
    output logic [DATA_WIDTH-1:0]   a_wr_data,
    output logic                    b_wr_en,
    output logic [DATA_WIDTH-1:0]   b_wr_data,
    output logic                    a_rd_en,
    output logic                    b_rd_en,
    input  logic [DATA_WIDTH-1:0]   a_rd_data,
    input  logic [DATA_WIDTH-1:0]   b_rd_data,
    input  logic                    a_full,
    input  logic                    b_full,
    input  logic                    a_empty,
    input  logic                    b_empty,
    output logic                    win_vld,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic [CNT_W-1:0]        win_row,
    output logic [CNT_W-1:0]        win_col,
    output logic                    frame_done,
    output logic                    err_abort,
    output logic                    err_ovf,
    output logic [2:0]              dbg_state
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] WIN_MIN  = CNT_W'(2);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        col_q, col_d;
    logic [CNT_W-1:0]        row_q, row_d;
    logic                    drain_wait_q, drain_wait_d;

    // Stage 1: the accepted pixel waiting for its FIFO read data.
    logic                    s1_vld_q, s1_vld_d;
    logic                    s1_bwr_q, s1_bwr_d;
    logic [DATA_WIDTH-1:0]   s1_pix_q, s1_pix_d;
    logic [CNT_W-1:0]        s1_row_q, s1_row_d;
    logic [CNT_W-1:0]        s1_col_q, s1_col_d;

    // Stage 2: output qualifiers.
    logic                    win_vld_q, win_vld_d;
    logic [CNT_W-1:0]        win_row_q, win_row_d;
    logic [CNT_W-1:0]        win_col_q, win_col_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_abort_q, err_abort_d;
    logic                    err_ovf_q, err_ovf_d;

    logic                    active;
    logic                    start;
    logic                    abort;
    logic                    accept;
    logic                    col_end;
    logic                    rd_a_pix;
    logic                    rd_b_pix;
    logic                    drain_rd_ok;
    logic                    drain_done;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        drain_wait_d = 1'b0;

        active   = (state_q == ST_FILL0) || (state_q == ST_FILL1) || (state_q == ST_RUN);
        start    = (state_q == ST_IDLE) && sof && pix_vld;
        // A second sof inside a frame aborts it; that pixel is not consumed.
        abort    = active && sof && pix_vld;
        accept   = start || (active && pix_vld && !sof);
        col_end  = (col_q == COL_LAST);
        rd_a_pix = accept && ((state_q == ST_FILL1) || (state_q == ST_RUN));
        rd_b_pix = accept && (state_q == ST_RUN);

        // The first DRAIN cycle is spent letting the last line_b write land,
        // so the empty flags are only trusted from the second cycle on.
        drain_rd_ok = (state_q == ST_DRAIN) && !drain_wait_q;
        drain_done  = drain_rd_ok && a_empty && b_empty && !s1_bwr_q;

        a_wr_en   = accept;
        a_wr_data = accept ? pix_data : '0;
        b_wr_en   = s1_bwr_q;
        b_wr_data = s1_bwr_q ? a_rd_data : '0;
        a_rd_en   = rd_a_pix || (drain_rd_ok && !a_empty);
        b_rd_en   = rd_b_pix || (drain_rd_ok && !b_empty);

        if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FILL0;
            ST_FILL0: begin
                if (abort)                 state_d = ST_DRAIN;
                else if (accept && col_end) state_d = ST_FILL1;
            end
            ST_FILL1: begin
                if (abort)                 state_d = ST_DRAIN;
                else if (accept && col_end) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                                         state_d = ST_DRAIN;
                else if (accept && col_end && (row_q == ROW_LAST)) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (drain_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Counters are parked at zero outside a frame so the sof pixel is (0,0).
        if (state_d == ST_DRAIN) begin
            col_d = '0;
            row_d = '0;
        end
        drain_wait_d = (state_d == ST_DRAIN) && (state_q != ST_DRAIN);

        s1_vld_d = accept;
        s1_bwr_d = rd_a_pix;
        s1_pix_d = accept ? pix_data : s1_pix_q;
        s1_row_d = accept ? row_q    : s1_row_q;
        s1_col_d = accept ? col_q    : s1_col_q;

        // Window columns are never cleared at row start; the col>=2 gate
        // hides windows that still hold the previous row's tail.
        win_vld_d = s1_vld_q && (s1_row_q >= WIN_MIN) && (s1_col_q >= WIN_MIN);
        win_row_d = s1_vld_q ? s1_row_q : win_row_q;
        win_col_d = s1_vld_q ? s1_col_q : win_col_q;

        frame_done_d = drain_done;
        err_abort_d  = abort;
        err_ovf_d    = err_ovf_q || (accept && a_full) || (s1_bwr_q && b_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            drain_wait_q <= 1'b0;
            s1_vld_q     <= 1'b0;
            s1_bwr_q     <= 1'b0;
            s1_pix_q     <= '0;
            s1_row_q     <= '0;
            s1_col_q     <= '0;
            win_vld_q    <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
            err_abort_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            drain_wait_q <= drain_wait_d;
            s1_vld_q     <= s1_vld_d;
            s1_bwr_q     <= s1_bwr_d;
            s1_pix_q     <= s1_pix_d;
            s1_row_q     <= s1_row_d;
            s1_col_q     <= s1_col_d;
            win_vld_q    <= win_vld_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
            err_abort_q  <= err_abort_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    // Column tap: row 0 = oldest line (line_b), row 2 = current pixel.
    win_shift_3x3 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_win (
        .clk      (clk),
        .rst      (rst),
        .shift_en (s1_vld_q),
        .tap_col  ({s1_pix_q, a_rd_data, b_rd_data}),
        .win      (win_data)
    );

    assign win_vld    = win_vld_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;
    assign err_abort  = err_abort_q;
    assign err_ovf    = err_ovf_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_matrix_3x3_ctrl.sv
module tb_matrix_3x3_ctrl;
    import matrix_3x3_pkg::*;

    localparam int DW = 10;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int CW = 8;
    localparam int EW = 32 + CW + CW + 9*DW;

    logic            clk;
    logic            rst;
    logic            sof;
    logic            pix_vld;
    logic [DW-1:0]   pix_data;
    logic            a_wr_en, b_wr_en, a_rd_en, b_rd_en;
    logic [DW-1:0]   a_wr_data, b_wr_data, a_rd_data, b_rd_data;
    logic            a_full, b_full, a_empty, b_empty;
    logic            win_vld;
    logic [9*DW-1:0] win_data;
    logic [CW-1:0]   win_row, win_col;
    logic            frame_done, err_abort, err_ovf;
    logic [2:0]      dbg_state;

    matrix_3x3_ctrl #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .pix_vld    (pix_vld),
        .pix_data   (pix_data),
        .a_wr_en    (a_wr_en),
        .a_wr_data  (a_wr_data),
        .b_wr_en    (b_wr_en),
        .b_wr_data  (b_wr_data),
        .a_rd_en    (a_rd_en),
        .b_rd_en    (b_rd_en),
        .a_rd_data  (a_rd_data),
        .b_rd_data  (b_rd_data),
        .a_full     (a_full),
        .b_full     (b_full),
        .a_empty    (a_empty),
        .b_empty    (b_empty),
        .win_vld    (win_vld),
        .win_data   (win_data),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done),
        .err_abort  (err_abort),
        .err_ovf    (err_ovf),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- line FIFO models (16 deep, registered read) ----------------
    logic [DW-1:0] a_mem [16];
    logic [DW-1:0] b_mem [16];
    int a_cnt = 0, a_wp = 0, a_rp = 0;
    int b_cnt = 0, b_wp = 0, b_rp = 0;
    logic force_a_full = 1'b0;

    assign a_full  = (a_cnt >= 16) || force_a_full;
    assign a_empty = (a_cnt == 0);
    assign b_full  = (b_cnt >= 16);
    assign b_empty = (b_cnt == 0);

    always @(posedge clk) begin
        if (rst) begin
            a_cnt <= 0; a_wp <= 0; a_rp <= 0; a_rd_data <= '0;
        end else begin
            if (a_wr_en && !a_full) begin
                a_mem[a_wp] <= a_wr_data;
                a_wp <= (a_wp + 1) % 16;
            end
            if (a_rd_en && !a_empty) begin
                a_rd_data <= a_mem[a_rp];
                a_rp <= (a_rp + 1) % 16;
            end
            a_cnt <= a_cnt + ((a_wr_en && !a_full) ? 1 : 0) - ((a_rd_en && !a_empty) ? 1 : 0);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            b_cnt <= 0; b_wp <= 0; b_rp <= 0; b_rd_data <= '0;
        end else begin
            if (b_wr_en && !b_full) begin
                b_mem[b_wp] <= b_wr_data;
                b_wp <= (b_wp + 1) % 16;
            end
            if (b_rd_en && !b_empty) begin
                b_rd_data <= b_mem[b_rp];
                b_rp <= (b_rp + 1) % 16;
            end
            b_cnt <= b_cnt + ((b_wr_en && !b_full) ? 1 : 0) - ((b_rd_en && !b_empty) ? 1 : 0);
        end
    end

    // ---------------- check helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Entry = {expected cycle, row, col, window data}.
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int win_cnt = 0;

    // Window around bottom-right pixel p: tap (rr,cc) is p - (2-rr)*16 - (2-cc)
    // because pixel values encode row*16+col.
    task automatic push_win(input logic [DW-1:0] p);
        logic [9*DW-1:0] d;
        d = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                d[(rr*3+cc)*DW +: DW] = p - DW'((2-rr)*16 + (2-cc));
            end
        end
        exp_q.push_back({32'(cyc + 2), CW'(p[7:4]), CW'(p[3:0]), d});
    endtask

    always @(negedge clk) begin
        if (!rst && win_vld) begin
            win_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL win_unexpected: got window row %0d col %0d data %0h, expected none (t=%0t)",
                         win_row, win_col, win_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("win_cycle", 128'(cyc), 128'(mon_e[EW-1 -: 32]));
                chk("win_row", 128'(win_row), 128'(mon_e[9*DW+2*CW-1 -: CW]));
                chk("win_col", 128'(win_col), 128'(mon_e[9*DW+CW-1 -: CW]));
                chk("win_data", 128'(win_data), 128'(mon_e[9*DW-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic [DW-1:0] p, input bit ew);
        sof      = s;
        pix_vld  = 1'b1;
        pix_data = p;
        if (ew) push_win(p);
        tick();
        sof     = 1'b0;
        pix_vld = 1'b0;
    endtask

    task automatic bubble();
        sof     = 1'b0;
        pix_vld = 1'b0;
        tick();
    endtask

    task automatic run_frame(input logic [DW-1:0] base, input bit gap);
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                send(r == 0 && c == 0, base + DW'(r*16 + c), r >= 2 && c >= 2);
                if (gap) bubble();
            end
        end
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (frame_done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk(name, 128'(got), 128'(1));
        chk({name, "_state"}, 128'(dbg_state), 128'(ST_IDLE));
        tick();
        chk({name, "_pulse"}, 128'(frame_done), 128'(0));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctrl"}, 128'({a_wr_en, b_wr_en, a_rd_en, b_rd_en, win_vld,
                                   frame_done, err_abort, err_ovf}), 128'(0));
        chk({name, "_wr_data"}, 128'({a_wr_data, b_wr_data}), 128'(0));
        chk({name, "_win"}, 128'({win_row, win_col, win_data}), 128'(0));
        chk({name, "_state"}, 128'(dbg_state), 128'(ST_IDLE));
    endtask

    // ---------------- vector table ----------------
    // e = expected {a_wr_en, b_wr_en, a_rd_en, b_rd_en, win_vld} in that cycle.
    typedef struct packed {
        logic          s;
        logic          v;
        logic [DW-1:0] p;
        logic [4:0]    e;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic s, input logic v, input logic [DW-1:0] p, input logic [4:0] e);
        vec_t t;
        t.s = s; t.v = v; t.p = p; t.e = e;
        tbl.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    int w0;

    initial begin
        // Back-to-back 4x4 frame followed by the drain.
        add_vec(1, 1, 10'h00, 5'b10000);
        add_vec(0, 1, 10'h01, 5'b10000);
        add_vec(0, 1, 10'h02, 5'b10000);
        add_vec(0, 1, 10'h03, 5'b10000);
        add_vec(0, 1, 10'h10, 5'b10100);
        add_vec(0, 1, 10'h11, 5'b11100);
        add_vec(0, 1, 10'h12, 5'b11100);
        add_vec(0, 1, 10'h13, 5'b11100);
        add_vec(0, 1, 10'h20, 5'b11110);
        add_vec(0, 1, 10'h21, 5'b11110);
        add_vec(0, 1, 10'h22, 5'b11110);
        add_vec(0, 1, 10'h23, 5'b11110);
        add_vec(0, 1, 10'h30, 5'b11111);
        add_vec(0, 1, 10'h31, 5'b11111);
        add_vec(0, 1, 10'h32, 5'b11110);
        add_vec(0, 1, 10'h33, 5'b11110);
        add_vec(0, 0, 10'h00, 5'b01001);
        add_vec(0, 0, 10'h00, 5'b00111);
        add_vec(0, 0, 10'h00, 5'b00110);
        add_vec(0, 0, 10'h00, 5'b00110);
        add_vec(0, 0, 10'h00, 5'b00110);

        rst = 1'b1; sof = 1'b0; pix_vld = 1'b0; pix_data = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1) table-driven full frame
        w0 = win_cnt;
        foreach (tbl[i]) begin
            sof      = tbl[i].s;
            pix_vld  = tbl[i].v;
            pix_data = tbl[i].p;
            if (tbl[i].v && tbl[i].p[7:4] >= 2 && tbl[i].p[3:0] >= 2) push_win(tbl[i].p);
            @(negedge clk);
            chk($sformatf("vec%0d_enables", i),
                128'({a_wr_en, b_wr_en, a_rd_en, b_rd_en, win_vld}), 128'(tbl[i].e));
            tick();
        end
        sof = 1'b0; pix_vld = 1'b0;
        wait_done("frame1_done");
        chk("frame1_win_count", 128'(win_cnt - w0), 128'(4));

        // 2) same frame with a bubble after every pixel
        w0 = win_cnt;
        run_frame(10'h000, 1'b1);
        wait_done("gap_done");
        chk("gap_win_count", 128'(win_cnt - w0), 128'(4));

        // 3) abort: sof again at pixel 0x21
        w0 = win_cnt;
        for (int i = 0; i < 9; i++) send(i == 0, DW'((i/4)*16 + i%4), 1'b0);
        sof = 1'b1; pix_vld = 1'b1; pix_data = 10'h21;
        @(negedge clk);
        chk("abort_pixel_dropped", 128'(a_wr_en), 128'(0));
        tick();
        sof = 1'b0; pix_vld = 1'b0;
        chk("abort_pulse", 128'(err_abort), 128'(1));
        chk("abort_state", 128'(dbg_state), 128'(ST_DRAIN));
        tick();
        chk("abort_pulse_len", 128'(err_abort), 128'(0));
        wait_done("abort_drain_done");
        chk("abort_fifos_empty", 128'({a_cnt == 0, b_cnt == 0}), 128'(2'b11));
        chk("abort_no_windows", 128'(win_cnt - w0), 128'(0));
        w0 = win_cnt;
        run_frame(10'h000, 1'b0);
        wait_done("after_abort_done");
        chk("after_abort_win_count", 128'(win_cnt - w0), 128'(4));

        // 4) reset at pixel 0x13, then pixels without sof are ignored
        for (int i = 0; i < 7; i++) send(i == 0, DW'((i/4)*16 + i%4), 1'b0);
        rst = 1'b1; pix_vld = 1'b1; pix_data = 10'h13;
        tick();
        rst = 1'b0; pix_vld = 1'b0;
        chk_all_zero("midrst");
        for (int i = 0; i < 4; i++) begin
            pix_vld = 1'b1; pix_data = DW'(10'h20 + i);
            @(negedge clk);
            chk($sformatf("nosof%0d_ignored", i), 128'({a_wr_en, a_rd_en, b_rd_en}), 128'(0));
            tick();
        end
        pix_vld = 1'b0;
        chk("nosof_state", 128'(dbg_state), 128'(ST_IDLE));

        // 5) two consecutive frames with distinct pixel bases
        w0 = win_cnt;
        run_frame(10'h000, 1'b0);
        wait_done("two_f1_done");
        run_frame(10'h100, 1'b0);
        wait_done("two_f2_done");
        chk("two_frames_win_count", 128'(win_cnt - w0), 128'(8));

        // 6) overflow: line_a reports full while pixel 0x33 is written
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                if (r == 3 && c == 3) begin
                    chk("ovf_clear_before", 128'(err_ovf), 128'(0));
                    force_a_full = 1'b1;
                end
                send(r == 0 && c == 0, DW'(r*16 + c), r >= 2 && c >= 2);
                force_a_full = 1'b0;
            end
        end
        chk("ovf_set", 128'(err_ovf), 128'(1));
        wait_done("ovf_done");
        repeat (5) tick();
        chk("ovf_sticky", 128'(err_ovf), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_rst_clear", 128'(err_ovf), 128'(0));

        repeat (4) tick();
        chk("exp_q_drained", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
